// File: rtl/guard_insert_pkg.sv
// Shared definitions for the guard-interval inserter: reader FSM encodings and
// the address-width helper.
package guard_insert_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_GUARD = 2'd1;
  localparam state_t ST_BODY  = 2'd2;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/guard_insert_if.sv
// Sample-stream bundle for guard_insert: input beats with ready/valid and the
// non-backpressured output stream with a symbol-start marker.
interface guard_insert_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_i;
  logic [W-1:0] x_q;
  logic         out_valid;
  logic         sym_start;
  logic [W-1:0] y_i;
  logic [W-1:0] y_q;

  modport master (
    output in_valid, x_i, x_q,
    input  in_ready, out_valid, sym_start, y_i, y_q
  );

  modport slave (
    input  in_valid, x_i, x_q,
    output in_ready, out_valid, sym_start, y_i, y_q
  );
endinterface

// File: rtl/guard_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; the bank select is the
// address MSB. One write port, one registered read port, no reset on storage.
module guard_bank_ram #(
  parameter int DW = 32,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/guard_insert.sv
// Guard-interval inserter: buffers N-sample symbols in two banks and replays
// each one preceded by G guard samples (cyclic prefix or zeros).
module guard_insert
  import guard_insert_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 64,
  parameter int G = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cp_mode,
  guard_insert_if.slave  bus
);
  localparam int            AW    = clog2(N);
  localparam logic [AW-1:0] LAST  = AW'(N - 1);
  localparam logic [AW-1:0] GLAST = AW'(G - 1);
  localparam logic [AW-1:0] GOFF  = AW'(N - G);

  logic          wb_reg;
  logic [AW-1:0] waddr_reg;
  logic [1:0]    full_reg;
  logic [1:0]    full_next;
  logic          accept;
  logic          release_bank;

  state_t        state_reg, state_next;
  logic          rb_reg, rb_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          cp_reg, cp_next;

  logic          ov_reg, ss_reg, zero_reg;
  logic [AW:0]   rd_addr;
  logic [2*W-1:0] rd_data;

  assign bus.in_ready = ~full_reg[wb_reg];
  assign accept       = bus.in_valid & ~full_reg[wb_reg];

  always_comb begin
    state_next   = state_reg;
    rb_next      = rb_reg;
    cnt_next     = cnt_reg;
    cp_next      = cp_reg;
    release_bank = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (full_reg[rb_reg]) begin
          state_next = ST_GUARD;
          cnt_next   = '0;
          cp_next    = cp_mode;
        end
      end
      ST_GUARD: begin
        if (cnt_reg == GLAST) begin
          state_next = ST_BODY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + AW'(1);
        end
      end
      ST_BODY: begin
        if (cnt_reg == LAST) begin
          release_bank = 1'b1;
          rb_next      = ~rb_reg;
          cnt_next     = '0;
          // Chain straight into the next symbol when the other bank is ready.
          if (full_reg[~rb_reg]) begin
            state_next = ST_GUARD;
            cp_next    = cp_mode;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + AW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    full_next = full_reg;
    if (release_bank) full_next[rb_reg] = 1'b0;
    if (accept && waddr_reg == LAST) full_next[wb_reg] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_reg    <= 1'b0;
      waddr_reg <= '0;
      full_reg  <= 2'b00;
      state_reg <= ST_IDLE;
      rb_reg    <= 1'b0;
      cnt_reg   <= '0;
      cp_reg    <= 1'b0;
      ov_reg    <= 1'b0;
      ss_reg    <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      if (accept) begin
        waddr_reg <= waddr_reg + AW'(1);
        if (waddr_reg == LAST) wb_reg <= ~wb_reg;
      end
      full_reg  <= full_next;
      state_reg <= state_next;
      rb_reg    <= rb_next;
      cnt_reg   <= cnt_next;
      cp_reg    <= cp_next;
      ov_reg    <= (state_reg != ST_IDLE);
      ss_reg    <= (state_reg == ST_GUARD) && (cnt_reg == '0);
      zero_reg  <= (state_reg == ST_GUARD) && !cp_reg;
    end
  end

  // Guard samples replay the symbol tail, so offset the address by N-G.
  assign rd_addr = {rb_reg, (state_reg == ST_GUARD) ? (GOFF + cnt_reg) : cnt_reg};

  guard_bank_ram #(
    .DW(2 * W),
    .AW(AW + 1)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr ({wb_reg, waddr_reg}),
    .wdata ({bus.x_i, bus.x_q}),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign bus.out_valid = ov_reg;
  assign bus.sym_start = ss_reg;
  assign bus.y_i = (ov_reg && !zero_reg) ? rd_data[2*W-1:W] : '0;
  assign bus.y_q = (ov_reg && !zero_reg) ? rd_data[W-1:0]   : '0;
endmodule
